stall_flush_controller: RTL and testbench

STALL_FLUSH_CONTROLLER -- requirements
Module: stall_flush_controller

---
 rtl/stall_flush_controller.sv | 161 ++++++++++++++++
 tb/tb_stall_flush_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stall_flush_controller.sv
// stall_flush_controller
//   Pipeline hazard controller for a 5-stage core. Arbitrates between memory
//   waits, taken branches and load-use hazards, and produces per-register
//   freeze (hold) and flush (bubble) controls with zero added latency. Also
//   detects memory access timeouts and keeps saturating performance counters.
//
// Parameters
//   MEM_TIMEOUT    max consecutive memory-wait cycles before timeout (1..255)
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   hazard         load-use hazard request (same cycle)
//   branch_taken   taken branch resolved in EXE (same cycle)
//   mem_req        MEM-stage instruction accesses data memory
//   mem_ready      data memory completes the access this cycle
//   cnt_clr        synchronous clear of the performance counters
//   freeze_*       hold PC / pipeline register this cycle
//   flush_*        load a bubble into the register at the next edge
//   mem_timeout    sticky memory timeout error
//   *_cnt          16-bit saturating performance counters
module stall_flush_controller #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        cnt_clr,
  output logic        freeze_pc,
  output logic        freeze_if_id,
  output logic        freeze_id_ex,
  output logic        freeze_ex_mem,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        mem_timeout,
  output logic [15:0] load_stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] mem_wait_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       mem_timeout_reg, mem_timeout_next;
  logic       ms;
  logic       load_stall;
  logic       branch_flush;

  assign ms = mem_req & ~mem_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 8'd0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg;
    case (state_reg)
      RUN: begin
        if (ms) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          if (wait_cnt_reg < TIMEOUT_LIMIT) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end else begin
            state_next       = TIMEOUT;
            mem_timeout_next = 1'b1;
          end
        end else begin
          // The completed access leaves MEM at this edge, so a still-high
          // mem_req belongs to the old instruction: go back to RUN.
          state_next = RUN;
        end
      end
      TIMEOUT: begin
        state_next = TIMEOUT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Output logic (Mealy). A release cycle in MEM_WAIT behaves like RUN with
  // ms=0, so a branch held in EXE during the wait flushes on release.
  always_comb begin
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    freeze_id_ex  = 1'b0;
    freeze_ex_mem = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    load_stall    = 1'b0;
    branch_flush  = 1'b0;
    if (!rst) begin
      if ((state_reg == TIMEOUT) ||
          (state_reg == RUN && ms) ||
          (state_reg == MEM_WAIT && !mem_ready)) begin
        freeze_pc     = 1'b1;
        freeze_if_id  = 1'b1;
        freeze_id_ex  = 1'b1;
        freeze_ex_mem = 1'b1;
      end else if (branch_taken) begin
        // The hazard-dependent instruction is squashed by the flush anyway.
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        branch_flush = 1'b1;
      end else if (hazard) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        flush_id_ex  = 1'b1;
        load_stall   = 1'b1;
      end
    end
  end

  assign mem_timeout = mem_timeout_reg;

  // Performance counters: 0 = load stalls, 1 = branch flushes, 2 = mem waits.
  logic [2:0]  cnt_inc;
  logic [15:0] cnt_reg [3];

  assign cnt_inc = {freeze_ex_mem, branch_flush, load_stall};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
          cnt_reg[gi] <= 16'd0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign load_stall_cnt = cnt_reg[0];
  assign flush_cnt      = cnt_reg[1];
  assign mem_wait_cnt   = cnt_reg[2];

endmodule

// File: tb/tb_stall_flush_controller.sv
// Directed testbench for stall_flush_controller (MEM_TIMEOUT = 4).
module tb_stall_flush_controller;

  logic        clk;
  logic        rst;
  logic        hazard;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        cnt_clr;
  logic        freeze_pc;
  logic        freeze_if_id;
  logic        freeze_id_ex;
  logic        freeze_ex_mem;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        mem_timeout;
  logic [15:0] load_stall_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] mem_wait_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // {freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem, flush_if_id, flush_id_ex}
  logic [5:0] outs;
  localparam logic [5:0] NONE    = 6'b000000;
  localparam logic [5:0] FRZ_ALL = 6'b111100;
  localparam logic [5:0] BRF     = 6'b000011;
  localparam logic [5:0] HAZ     = 6'b110001;

  assign outs = {freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem,
                 flush_if_id, flush_id_ex};

  stall_flush_controller #(.MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .hazard         (hazard),
    .branch_taken   (branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .cnt_clr        (cnt_clr),
    .freeze_pc      (freeze_pc),
    .freeze_if_id   (freeze_if_id),
    .freeze_id_ex   (freeze_id_ex),
    .freeze_ex_mem  (freeze_ex_mem),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .mem_timeout    (mem_timeout),
    .load_stall_cnt (load_stall_cnt),
    .flush_cnt      (flush_cnt),
    .mem_wait_cnt   (mem_wait_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-24s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply inputs, then let combinational outputs settle before checking.
  task automatic drive(input logic r, input logic h, input logic b,
                       input logic mr, input logic rdy, input logic clr);
    rst = r; hazard = h; branch_taken = b;
    mem_req = mr; mem_ready = rdy; cnt_clr = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] ls,
                         input logic [15:0] fl, input logic [15:0] mw);
    chk({tag, "_load"}, {16'd0, load_stall_cnt}, {16'd0, ls});
    chk({tag, "_flush"}, {16'd0, flush_cnt}, {16'd0, fl});
    chk({tag, "_mwait"}, {16'd0, mem_wait_cnt}, {16'd0, mw});
  endtask

  initial begin
    // Reset with every request active: outputs must stay quiet.
    drive(1, 1, 1, 1, 0, 0);
    chk("rst_outs", {26'd0, outs}, {26'd0, NONE});
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("idle_outs", {26'd0, outs}, {26'd0, NONE});
    chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk_cnt("rst", 16'd0, 16'd0, 16'd0);

    // Single-cycle load-use hazard.
    drive(0, 1, 0, 0, 0, 0);
    chk("haz_outs", {26'd0, outs}, {26'd0, HAZ});
    tick();
    chk_cnt("haz", 16'd1, 16'd0, 16'd0);

    // Counter clear.
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk_cnt("clr", 16'd0, 16'd0, 16'd0);

    // Hazard and branch together: branch wins.
    drive(0, 1, 1, 0, 0, 0);
    chk("hazbr_outs", {26'd0, outs}, {26'd0, BRF});
    tick();
    chk_cnt("hazbr", 16'd0, 16'd1, 16'd0);

    // Three wait cycles with a branch held in EXE, then release.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0, 0);
      chk($sformatf("mw_frz%0d", i), {26'd0, outs}, {26'd0, FRZ_ALL});
      tick();
    end
    drive(0, 0, 1, 1, 1, 0);
    chk("release_outs", {26'd0, outs}, {26'd0, BRF});
    tick();
    chk_cnt("release", 16'd0, 16'd2, 16'd3);
    // Back in RUN: an idle bus must not freeze.
    drive(0, 0, 0, 0, 0, 0);
    chk("post_rel_outs", {26'd0, outs}, {26'd0, NONE});
    tick();

    // Timeout: 1 RUN wait cycle + 4 MEM_WAIT cycles, flag after the 5th edge.
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      chk($sformatf("to_frz%0d", i), {26'd0, outs}, {26'd0, FRZ_ALL});
      tick();
      chk($sformatf("to_flag%0d", i), {31'd0, mem_timeout}, (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 1, 1, 0);
      chk($sformatf("to_ign%0d", i), {26'd0, outs}, {26'd0, FRZ_ALL});
      tick();
    end
    chk("to_sticky", {31'd0, mem_timeout}, 32'd1);
    chk_cnt("to", 16'd0, 16'd2, 16'd10);
    // Counter clear leaves the timeout state alone.
    drive(0, 0, 0, 0, 0, 1);
    chk("to_clr_outs", {26'd0, outs}, {26'd0, FRZ_ALL});
    tick();
    chk("to_clr_flag", {31'd0, mem_timeout}, 32'd1);
    chk_cnt("to_clr", 16'd0, 16'd0, 16'd0);
    drive(1, 0, 0, 1, 0, 0);
    chk("to_rst_outs", {26'd0, outs}, {26'd0, NONE});
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("to_rec_outs", {26'd0, outs}, {26'd0, NONE});
    chk("to_rec_flag", {31'd0, mem_timeout}, 32'd0);

    // Reset in the middle of a memory wait (wait_cnt = 2).
    drive(0, 0, 0, 1, 0, 0);
    tick();
    tick();
    chk_cnt("mid_pre", 16'd0, 16'd0, 16'd2);
    drive(1, 0, 0, 1, 0, 0);
    chk("mid_rst_outs", {26'd0, outs}, {26'd0, NONE});
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("mid_rec_outs", {26'd0, outs}, {26'd0, NONE});
    chk_cnt("mid_rec", 16'd0, 16'd0, 16'd0);
    tick();
    chk("mid_rec2_outs", {26'd0, outs}, {26'd0, NONE});

    // Saturation: 70000 hazard cycles.
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    chk("sat_outs", {26'd0, outs}, {26'd0, HAZ});
    chk_cnt("sat", 16'hFFFF, 16'd0, 16'd0);
    drive(0, 1, 0, 0, 0, 1);
    tick();
    chk("sat_clr", {16'd0, load_stall_cnt}, 32'd0);
    drive(0, 1, 0, 0, 0, 0);
    tick();
    chk("sat_after", {16'd0, load_stall_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
